// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The controller side uses the master modport; the divider uses slave.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock.
// Each trial subtraction runs through the shared n-bit add/subtract datapath.

// N-bit add/subtract unit: add_n=0 adds, add_n=1 computes a - b as a + ~b + 1.
module seq_divider_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         add_n,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] b_eff;

  assign b_eff       = add_n ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, add_n};
endmodule

module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Trial subtraction of the shifted partial remainder against the divisor.
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic             no_borrow;
  logic             last_iter;

  assign s         = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  seq_divider_addsub #(.N(WIDTH + 1)) u_addsub (
    .a     (s),
    .b     ({1'b0, d_q}),
    .add_n (1'b1),
    .sum   (t),
    .cout  (no_borrow)
  );

  // A stays below the divisor after every step, so its top bit is never
  // shifted back in; it exists only to hold the full-width trial result.
  logic unused_a_msb;
  assign unused_a_msb = a_q[WIDTH];

  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    d_d         = d_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.dividend;
          d_d     = bus.divisor;
          cnt_d   = '0;
          state_d = (bus.divisor == '0) ? S_ZERO : S_RUN;
        end
      end

      S_RUN: begin
        if (no_borrow) begin
          a_d = t;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          a_d = s;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          quotient_d  = q_d;
          remainder_d = a_d[WIDTH-1:0];
          dbz_d       = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end

      // Q still holds the captured dividend, which becomes the remainder.
      S_ZERO: begin
        quotient_d  = '1;
        remainder_d = q_q;
        dbz_d       = 1'b1;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=8: directed vector table,
// multi-cycle handshake corners, mid-operation reset and a random sweep.
module tb_seq_divider;
  localparam int WIDTH = 8;
  localparam int LIMIT = 40;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dividend;
    int divisor;
    int exp_q;
    int exp_r;
    int exp_z;
    int exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present start with operands for one edge, then scramble the operand inputs.
  task automatic issue(input int dd, input int dv);
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(dd);
    bus.divisor  = WIDTH'(dv);
    step();
    bus.start    = 1'b0;
    bus.dividend = WIDTH'($urandom);
    bus.divisor  = WIDTH'($urandom);
  endtask

  // Count cycles from acceptance to done; optionally pulse start with 50/5 at cycle 'poke'.
  task automatic wait_done(input int poke, output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (!bus.done && lat < LIMIT) begin
      if (bus.busy) busy_n++;
      if (lat == poke) begin
        bus.start    = 1'b1;
        bus.dividend = WIDTH'(50);
        bus.divisor  = WIDTH'(5);
      end
      step();
      bus.start = 1'b0;
      lat++;
    end
    lat = lat - 1;
  endtask

  task automatic check_result(input string tag, input int q, input int r, input int z);
    check({tag, ".quotient"},    32'(bus.quotient),    32'(q));
    check({tag, ".remainder"},   32'(bus.remainder),   32'(r));
    check({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(z));
    check({tag, ".busy_in_done"}, 32'(bus.busy),       32'd0);
  endtask

  initial begin
    int lat;
    int busy_n;
    int dd;
    int dv;

    n_cmp        = 0;
    n_fail       = 0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    vecs[0]  = '{100,   7,  14,   2, 0, 8};
    vecs[1]  = '{255,   1, 255,   0, 0, 8};
    vecs[2]  = '{  3,  10,   0,   3, 0, 8};
    vecs[3]  = '{200, 200,   1,   0, 0, 8};
    vecs[4]  = '{  0,   5,   0,   0, 0, 8};
    vecs[5]  = '{ 42,   0, 255,  42, 1, 1};
    vecs[6]  = '{  9,   3,   3,   0, 0, 8};
    vecs[7]  = '{255, 255,   1,   0, 0, 8};
    vecs[8]  = '{  1, 255,   0,   1, 0, 8};
    vecs[9]  = '{128,   3,  42,   2, 0, 8};
    vecs[10] = '{254,  16,  15,  14, 0, 8};
    vecs[11] = '{  0,   0, 255,   0, 1, 1};

    // Reset state
    rst_n = 1'b0;
    #1;
    check("reset.busy",        32'(bus.busy),        32'd0);
    check("reset.done",        32'(bus.done),        32'd0);
    check("reset.quotient",    32'(bus.quotient),    32'd0);
    check("reset.remainder",   32'(bus.remainder),   32'd0);
    check("reset.div_by_zero", 32'(bus.div_by_zero), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Directed vector table, each followed by an idle hold check
    foreach (vecs[i]) begin
      issue(vecs[i].dividend, vecs[i].divisor);
      wait_done(-1, lat, busy_n);
      check($sformatf("vec%0d.latency", i), 32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("vec%0d.busy_cycles", i), 32'(busy_n), 32'(vecs[i].exp_lat));
      check_result($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_z);
      for (int k = 0; k < 3; k++) step();
      check($sformatf("vec%0d.done_single", i), 32'(bus.done),     32'd0);
      check($sformatf("vec%0d.hold_q", i),      32'(bus.quotient),  32'(vecs[i].exp_q));
      check($sformatf("vec%0d.hold_r", i),      32'(bus.remainder), 32'(vecs[i].exp_r));
    end

    // start during RUN is ignored; start in the done cycle is accepted back-to-back
    issue(100, 7);
    wait_done(2, lat, busy_n);
    check("ignore.latency", 32'(lat), 32'd8);
    check_result("ignore", 14, 2, 0);
    issue(50, 5);
    wait_done(-1, lat, busy_n);
    check("b2b.latency", 32'(lat), 32'd8);
    check_result("b2b", 10, 0, 0);
    step();
    check("b2b.done_single", 32'(bus.done), 32'd0);

    // Asynchronous reset in the fourth cycle of a division
    issue(100, 7);
    step();
    step();
    step();
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy",        32'(bus.busy),        32'd0);
    check("abort.done",        32'(bus.done),        32'd0);
    check("abort.quotient",    32'(bus.quotient),    32'd0);
    check("abort.remainder",   32'(bus.remainder),   32'd0);
    check("abort.div_by_zero", 32'(bus.div_by_zero), 32'd0);
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.done) lat++;
    end
    check("abort.no_done", 32'(lat), 32'd0);
    rst_n = 1'b1;
    step();
    issue(9, 2);
    wait_done(-1, lat, busy_n);
    check("post_reset.latency", 32'(lat), 32'd8);
    check_result("post_reset", 4, 1, 0);

    // Random sweep against / and %, with the invariant checked explicitly
    for (int n = 0; n < 200; n++) begin
      dd = int'($urandom_range(255, 0));
      dv = int'($urandom_range(255, 1));
      issue(dd, dv);
      wait_done(-1, lat, busy_n);
      check("rand.latency", 32'(lat), 32'd8);
      check_result("rand", dd / dv, dd % dv, 0);
      check("rand.invariant", 32'(int'(bus.quotient) * dv + int'(bus.remainder)), 32'(dd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
